// File: rtl/pm_add_pipe_if.sv
// pm_add_pipe_if: operand-in / result-out handshake bundle for the path-metric adder.
// Latency: none, wiring only.
// Backpressure: in_ready/out_ready carry the stall in each direction.
interface pm_add_pipe_if #(
    parameter int W  = 8,
    parameter int BW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  pm;
    logic [BW-1:0] bm;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          ovf;

    // adder side
    modport slave (
        input  in_valid, pm, bm, cin, out_ready,
        output in_ready, out_valid, sum, ovf
    );

    // producer/consumer side
    modport master (
        output in_valid, pm, bm, cin, out_ready,
        input  in_ready, out_valid, sum, ovf
    );
endinterface

// File: rtl/pm_add_pipe.sv
// pm_add_pipe: pm + zero-extended bm + cin, carry chain cut into STAGES registered segments, wrap or saturate.
// Latency: STAGES cycles from the accepting edge to out_valid.
// Backpressure: single global advance; out_valid & !out_ready freezes every stage and drops in_ready.
module pm_add_pipe #(
    parameter int W      = 8,
    parameter int BW     = 3,
    parameter int STAGES = 2,
    parameter int SAT    = 0
) (
    input logic          clk,
    input logic          rst,
    pm_add_pipe_if.slave io
);
    // Bits per carry segment; trailing stages may own a short or empty segment.
    localparam int SEG = (W + STAGES - 1) / STAGES;

    // Per-stage registers: valid, carry-out, result bits finished so far, skewed operands.
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cy_q;
    logic [W-1:0]      acc_q [STAGES];
    logic [W-1:0]      pmr_q [STAGES];
    logic [W-1:0]      bmr_q [STAGES];

    // What each stage sees at its input, and what it will register.
    logic [STAGES-1:0] src_vld;
    logic [STAGES-1:0] src_cy;
    logic [W-1:0]      src_pm  [STAGES];
    logic [W-1:0]      src_bm  [STAGES];
    logic [W-1:0]      src_acc [STAGES];
    logic [STAGES-1:0] cy_d;
    logic [W-1:0]      acc_d   [STAGES];

    logic adv;

    // Whole pipe moves together unless a finished result is being refused.
    assign adv         = !vld_q[STAGES-1] || io.out_ready;
    assign io.in_ready = adv;

    // Stage 0 takes the raw operands; later stages take their predecessor's registers.
    always_comb begin
        src_vld[0] = io.in_valid;
        src_cy[0]  = io.cin;
        src_pm[0]  = io.pm;
        src_bm[0]  = W'(io.bm);
        src_acc[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = vld_q[k-1];
            src_cy[k]  = cy_q[k-1];
            src_pm[k]  = pmr_q[k-1];
            src_bm[k]  = bmr_q[k-1];
            src_acc[k] = acc_q[k-1];
        end
    end

    // Ripple each stage's carry through the bits of its own segment only.
    always_comb begin
        logic c;
        c = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            acc_d[k] = src_acc[k];
            c        = src_cy[k];
            for (int b = 0; b < W; b++) begin
                if (b >= k * SEG && b < (k + 1) * SEG) begin
                    acc_d[k][b] = src_pm[k][b] ^ src_bm[k][b] ^ c;
                    c = (src_pm[k][b] & src_bm[k][b]) | (c & (src_pm[k][b] ^ src_bm[k][b]));
                end
            end
            cy_d[k] = c;
        end
    end

    // Pipeline registers: load on advance, otherwise hold; reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                acc_q[k] <= '0;
                pmr_q[k] <= '0;
                bmr_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= src_vld;
            cy_q  <= cy_d;
            for (int k = 0; k < STAGES; k++) begin
                acc_q[k] <= acc_d[k];
                pmr_q[k] <= src_pm[k];
                bmr_q[k] <= src_bm[k];
            end
        end
    end

    // Carry out of the top segment is the overflow flag in both modes.
    assign io.out_valid = vld_q[STAGES-1];
    assign io.ovf       = cy_q[STAGES-1];
    assign io.sum       = (SAT != 0 && cy_q[STAGES-1]) ? {W{1'b1}} : acc_q[STAGES-1];
endmodule

// File: doc/pm_add_pipe.md
# pm_add_pipe

Parametrised, pipelined ripple-carry path-metric adder for the Viterbi decoder's add-compare-select datapath. Computes `pm + bm + cin`, with `bm` zero-extended, at a configurable width. The carry chain is split into `STAGES` registered segments so wide metrics close timing. Results leave through a valid/ready handshake with full back-pressure, and overflow is either wrapped (modulo) or saturated, selected by parameter.

## Interface
- `W`, default 8: path-metric / sum width. Legal range 2..32.
- `BW`, default 3: branch-metric width. Must satisfy 1 ≤ BW ≤ W.
- `STAGES`, default 2: pipeline depth, equal to the number of carry segments. Legal range 1..W.
- `SAT`, default 0: overflow mode.
  - 0: wrap, `sum = (pm+bm+cin) mod 2^W`.
  - 1: saturate to 2^W−1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input operands valid.
- `in_ready` out 1: block accepts the operands this cycle.
- `pm` in W: path metric, unsigned.
- `bm` in BW: branch metric, unsigned, zero-extended to W.
- `cin` in 1: carry-in.
- `out_valid` out 1: `sum`/`ovf` valid.
- `out_ready` in 1: downstream accepts.
- `sum` out W: result.
- `ovf` out 1: carry-out of bit W−1 for this result. Set in both modes.

## Operation
- `SEG = ceil(W/STAGES)`. Segment k covers bits [k·SEG, min((k+1)·SEG, W)−1]. The last segment may be narrower.
- Stage k (k = 0..STAGES−1) adds segment k of `pm` and zero-extended `bm` plus a carry:
  - stage 0 uses `cin`;
  - stage k>0 uses the carry registered by stage k−1.
- Stage k registers:
  - its segment sum;
  - its carry-out;
  - all result bits already computed below it;
  - the operand bits of segments above it (skew registers).
- Each stage has a valid bit. `out_valid` is the valid bit of the last stage.
- Global advance: `adv = !out_valid | out_ready`.
  - `in_ready = adv`. This is combinational from `out_valid`/`out_ready` only, not from `in_valid`.
  - When `adv` is 1, every stage loads from its predecessor. Stage 0 loads the inputs, and its valid bit takes `in_valid`.
  - When `adv` is 0, all stages hold.
- Bubbles propagate as invalid stages. Results emerge in input order, with no reordering or loss.
- Final stage output:
  - `ovf` = carry-out of the top segment.
  - If `SAT`=1 and `ovf`=1, `sum` = 2^W−1.
  - Otherwise `sum` = the raw W-bit sum.
- Max input `(2^W−1) + (2^BW−1) + 1` < 2^(W+1), so a single carry-out bit fully captures overflow.
- No internal state survives a transaction. The block is a pure pipeline.

## Timing
- Latency is exactly `STAGES` cycles from the accepting edge (`in_valid & in_ready`) to `out_valid` high, provided `out_ready` stays high.
- Throughput: 1 result/cycle with `out_ready` held high.
- With `out_ready` low and `out_valid` high:
  - pipe freezes;
  - `in_ready` = 0;
  - `sum`/`ovf` stay stable until accepted.
- An output is consumed on a cycle with `out_valid & out_ready`. A new input may be accepted the same cycle.
- Reset values: all stage valid bits 0, `out_valid` 0, `sum` 0, `ovf` 0, all data/skew/carry registers 0.
  - `in_ready` = 1 combinationally while `out_valid` = 0.
- Reset asserted mid-operation drops all in-flight results immediately, asynchronously. The first accepted input after deassertion appears `STAGES` cycles later.
- `STAGES`=1: single registered adder, latency 1.
- `STAGES`=W: one bit per stage.
- Inputs are sampled only on the accepting edge. Changing `pm`/`bm`/`cin` while `in_ready`=0 has no effect.

## Test plan
- W=8, BW=3, STAGES=2, SAT=0; pm=10, bm=5, cin=0 → `sum`=15, `ovf`=0, `out_valid` exactly 2 cycles after accept.
- Same config; pm=15, bm=1, cin=0 (carry crosses the 4-bit segment boundary) → `sum`=16, `ovf`=0.
- pm=250, bm=7, cin=1:
  - SAT=0 → `sum`=2, `ovf`=1;
  - SAT=1 → `sum`=255, `ovf`=1.
- Back-pressure: stream pm=1,2,3,4,5 with bm=1 and `in_valid` high. Drop `out_ready` for 3 cycles once the first result is out → `in_ready` low during the stall, `sum` held. Outputs 2,3,4,5,6 arrive in order, none lost or duplicated.
- Reset mid-stream: assert `rst` with 2 results in flight → `out_valid`, `sum`, `ovf` go to 0 at once. After release, pm=100, bm=3 → `sum`=103 after 2 cycles.
- Configs W=16/STAGES=1 and W=16/STAGES=16, SAT=0, with pm=65535, bm=0, cin=1 → `sum`=0, `ovf`=1. Latency 1 and 16 respectively.
